slice_detector: RTL

//  Consumes cursor position/button (from the mouse move stage) and one object's box (from object motion).

---
 rtl/slice_detector_pkg.sv | 40 ++++
 rtl/slice_detector_if.sv | 25 ++
 rtl/slice_detector_tick_sync.sv | 18 +
 rtl/slice_detector.sv | 127 ++++++++++++
 4 files changed

// File: rtl/slice_detector_pkg.sv
// Shared types, defaults and helpers for the slice detector and its consumers.
// State and direction codes are exported here so game/score logic decodes them identically.
package slice_detector_pkg;

    localparam int unsigned X_W             = 10;
    localparam int unsigned Y_W             = 9;
    localparam int unsigned SCORE_W         = 16;
    localparam int unsigned DEF_MIN_SPEED   = 4;
    localparam int unsigned DEF_MAX_INSIDE  = 8;
    localparam int unsigned DEF_COOLDOWN    = 3;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_STROKE   = 2'd1,
        ST_INSIDE   = 2'd2,
        ST_COOLDOWN = 2'd3
    } state_e;

    typedef enum logic [1:0] {
        DIR_L2R = 2'b00,
        DIR_R2L = 2'b01,
        DIR_T2B = 2'b10,
        DIR_B2T = 2'b11
    } dir_e;

    typedef struct packed {
        logic [X_W-1:0] x;
        logic [Y_W-1:0] y;
        logic [X_W-1:0] w;
        logic [Y_W-1:0] h;
        logic           valid;
    } obj_box_t;

    // {vert_dominant, negative}; ties resolve to horizontal
    function automatic logic [1:0] slash_dir(input logic [10:0] ex, input logic [10:0] ey,
                                             input logic neg_x, input logic neg_y);
        return (ey > ex) ? {1'b1, neg_y} : {1'b0, neg_x};
    endfunction

endpackage

// File: rtl/slice_detector_if.sv
// Cursor/object inputs and slice results of one sliceable object.
interface slice_detector_if;
    import slice_detector_pkg::*;

    logic               moveclk;
    logic [X_W-1:0]     cursor_x;
    logic [Y_W-1:0]     cursor_y;
    logic               mousepush;
    obj_box_t           obj;
    logic               slice_pulse;
    logic [1:0]         slice_dir;
    logic [SCORE_W-1:0] score;
    logic               busy;

    modport master (
        output moveclk, cursor_x, cursor_y, mousepush, obj,
        input  slice_pulse, slice_dir, score, busy
    );

    modport slave (
        input  moveclk, cursor_x, cursor_y, mousepush, obj,
        output slice_pulse, slice_dir, score, busy
    );

endinterface

// File: rtl/slice_detector_tick_sync.sv
// Two-flop sampler with rising-edge detect for a slow level treated as data.
module slice_detector_tick_sync (
    input  logic clk,
    input  logic rst,
    input  logic i_d,
    output logic o_rise_c
);

    logic [1:0] r_sample;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_sample <= 2'b00;
        else     r_sample <= {r_sample[0], i_d};
    end

    assign o_rise_c = (r_sample == 2'b01);

endmodule

// File: rtl/slice_detector.sv
// Detects a fast pressed stroke that enters and then leaves one object's box;
// emits a one-cycle slice pulse, keeps a saturating score and the slash direction.
module slice_detector
    import slice_detector_pkg::*;
#(
    parameter int unsigned MIN_SPEED      = DEF_MIN_SPEED,
    parameter int unsigned MAX_INSIDE     = DEF_MAX_INSIDE,
    parameter int unsigned COOLDOWN_TICKS = DEF_COOLDOWN
) (
    input logic             clk,
    input logic             rst,
    slice_detector_if.slave bus
);

    localparam int unsigned CNT_MAX = (MAX_INSIDE > COOLDOWN_TICKS) ? MAX_INSIDE : COOLDOWN_TICKS;
    localparam int unsigned CNT_W   = (CNT_MAX > 2) ? $clog2(CNT_MAX) : 1;

    state_e             r_state;
    logic [X_W-1:0]     r_prev_x;
    logic [Y_W-1:0]     r_prev_y;
    logic [X_W-1:0]     r_entry_x;
    logic [Y_W-1:0]     r_entry_y;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_pulse;
    logic [1:0]         r_dir;
    logic [SCORE_W-1:0] r_score;

    logic               w_tick;
    logic [X_W:0]       w_x_end;
    logic [Y_W:0]       w_y_end;
    logic               w_inside;
    logic [X_W-1:0]     w_dx;
    logic [Y_W-1:0]     w_dy;
    logic [10:0]        w_speed;
    logic               w_fast;
    logic [X_W-1:0]     w_ex;
    logic [Y_W-1:0]     w_ey;
    logic [1:0]         w_dir;

    slice_detector_tick_sync u_tick_sync (
        .clk      (clk),
        .rst      (rst),
        .i_d      (bus.moveclk),
        .o_rise_c (w_tick)
    );

    // Box test with one extra bit on the far edge so x+w cannot wrap
    assign w_x_end  = (X_W+1)'(bus.obj.x) + (X_W+1)'(bus.obj.w);
    assign w_y_end  = (Y_W+1)'(bus.obj.y) + (Y_W+1)'(bus.obj.h);
    assign w_inside = bus.obj.valid
                    & (bus.cursor_x >= bus.obj.x) & ((X_W+1)'(bus.cursor_x) < w_x_end)
                    & (bus.cursor_y >= bus.obj.y) & ((Y_W+1)'(bus.cursor_y) < w_y_end);

    assign w_dx    = (bus.cursor_x >= r_prev_x) ? bus.cursor_x - r_prev_x : r_prev_x - bus.cursor_x;
    assign w_dy    = (bus.cursor_y >= r_prev_y) ? bus.cursor_y - r_prev_y : r_prev_y - bus.cursor_y;
    assign w_speed = 11'(w_dx) + 11'(w_dy);
    assign w_fast  = (w_speed >= 11'(MIN_SPEED));

    assign w_ex  = (bus.cursor_x >= r_entry_x) ? bus.cursor_x - r_entry_x : r_entry_x - bus.cursor_x;
    assign w_ey  = (bus.cursor_y >= r_entry_y) ? bus.cursor_y - r_entry_y : r_entry_y - bus.cursor_y;
    assign w_dir = slash_dir(11'(w_ex), 11'(w_ey),
                             bus.cursor_x < r_entry_x, bus.cursor_y < r_entry_y);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_prev_x  <= '0;
            r_prev_y  <= '0;
            r_entry_x <= '0;
            r_entry_y <= '0;
            r_cnt     <= '0;
            r_pulse   <= 1'b0;
            r_dir     <= 2'b00;
            r_score   <= '0;
        end else begin
            r_pulse <= 1'b0;
            if (w_tick) begin
                r_prev_x <= bus.cursor_x;
                r_prev_y <= bus.cursor_y;
                case (r_state)
                    ST_IDLE: begin
                        if (bus.mousepush) r_state <= ST_STROKE;
                    end
                    ST_STROKE: begin
                        if (!bus.mousepush) begin
                            r_state <= ST_IDLE;
                        end else if (w_inside && w_fast) begin
                            r_state   <= ST_INSIDE;
                            r_entry_x <= bus.cursor_x;
                            r_entry_y <= bus.cursor_y;
                            r_cnt     <= '0;
                        end
                    end
                    ST_INSIDE: begin
                        // Losing the object or the button aborts without scoring
                        if (!bus.mousepush || !bus.obj.valid) begin
                            r_state <= ST_IDLE;
                        end else if (!w_inside) begin
                            r_pulse <= 1'b1;
                            r_dir   <= w_dir;
                            if (!(&r_score)) r_score <= r_score + SCORE_W'(1);
                            r_state <= ST_COOLDOWN;
                            r_cnt   <= '0;
                        end else if (r_cnt == CNT_W'(MAX_INSIDE - 1)) begin
                            r_state <= ST_STROKE;
                        end else begin
                            r_cnt <= r_cnt + CNT_W'(1);
                        end
                    end
                    ST_COOLDOWN: begin
                        if (r_cnt == CNT_W'(COOLDOWN_TICKS - 1))
                            r_state <= bus.mousepush ? ST_STROKE : ST_IDLE;
                        else
                            r_cnt <= r_cnt + CNT_W'(1);
                    end
                    default: r_state <= ST_IDLE;
                endcase
            end
        end
    end

    assign bus.slice_pulse = r_pulse;
    assign bus.slice_dir   = r_dir;
    assign bus.score       = r_score;
    assign bus.busy        = (r_state != ST_IDLE);

endmodule
